// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline: bus widths, opcode/func encodings,
// ALU operation bit positions and the decode-to-execute bus layout.
package cpu_pkg;

    localparam int FS_TO_DS_BUS_W = 64;
    localparam int BR_BUS_W       = 33;
    localparam int DS_TO_ES_BUS_W = 137;
    localparam int ALU_OP_W       = 12;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Field order is MSB first and must total DS_TO_ES_BUS_W bits.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                src1_is_sa;
        logic                src1_is_pc;
        logic                src2_is_imm;
        logic                src2_is_zimm;
        logic                src2_is_8;
        logic                load_op;
        logic                mem_we;
        logic                rf_we;
        logic [4:0]          rf_waddr;
        logic [15:0]         imm;
        logic [31:0]         rs_val;
        logic [31:0]         rt_val;
        logic [31:0]         pc;
    } ds_to_es_t;

endpackage

// File: rtl/byp_mux.sv
// Per-operand forwarding selector: picks the youngest matching producer and
// flags a hazard when that producer's result is not yet available.
module byp_mux #(
    parameter int NUM_BYP = 3,
    parameter int BYP_EN  = 1
) (
    input  logic [4:0]            src,
    input  logic                  used,
    input  logic [31:0]           rf_data,
    input  logic [NUM_BYP-1:0]    byp_valid,
    input  logic [NUM_BYP-1:0]    byp_we,
    input  logic [5*NUM_BYP-1:0]  byp_waddr,
    input  logic [32*NUM_BYP-1:0] byp_wdata,
    input  logic [NUM_BYP-1:0]    byp_data_ok,
    output logic [31:0]           value,
    output logic                  hazard
);

    logic [NUM_BYP-1:0] match;
    logic               hit;
    logic               sel_ok;
    logic [31:0]        sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYP; gi++) begin : g_match
            assign match[gi] = byp_valid[gi] & byp_we[gi]
                             & (byp_waddr[5*gi +: 5] == src) & (src != 5'd0);
        end
    endgenerate

    // Scan oldest to youngest so the lowest index wins.
    always_comb begin
        hit      = 1'b0;
        sel_ok   = 1'b0;
        sel_data = 32'd0;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                sel_ok   = byp_data_ok[i];
                sel_data = byp_wdata[32*i +: 32];
            end
        end
    end

    assign value  = ((BYP_EN != 0) && hit) ? sel_data : rf_data;
    assign hazard = used & hit & ((BYP_EN != 0) ? ~sel_ok : 1'b1);

endmodule

// File: rtl/decoder_6_64.sv
// One-hot decoder from a 6-bit field to 64 select lines.
module decoder_6_64 (
    input  logic [5:0]  in,
    output logic [63:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_dec
            assign out[gi] = (in == 6'(gi));
        end
    endgenerate

endmodule

// File: rtl/id_stage_bypass.sv
// Decode stage with operand forwarding, load-use interlock, flush, branch
// resolution and a saturating stall-cycle counter.
module id_stage_bypass
    import cpu_pkg::*;
#(
    parameter int NUM_BYP     = 3,
    parameter int BYP_EN      = 1,
    parameter int STALL_CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      es_allowin,
    output logic                      ds_allowin,
    input  logic                      fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
    input  logic                      flush,
    output logic [BR_BUS_W-1:0]       br_bus,
    output logic                      ds_to_es_valid,
    output logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus,
    output logic [4:0]                rs_addr,
    output logic [4:0]                rt_addr,
    input  logic [31:0]               rs_data,
    input  logic [31:0]               rt_data,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP-1:0]        byp_we,
    input  logic [5*NUM_BYP-1:0]      byp_waddr,
    input  logic [32*NUM_BYP-1:0]     byp_wdata,
    input  logic [NUM_BYP-1:0]        byp_data_ok,
    output logic [STALL_CNT_W-1:0]    stall_cycles
);

    logic                      ds_valid_reg;
    logic [FS_TO_DS_BUS_W-1:0] ds_bus_reg;
    logic [STALL_CNT_W-1:0]    stall_cnt_reg;

    logic [31:0] ds_pc, ds_inst, pc4, rs_val, rt_val;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dest;
    logic [15:0] imm;
    logic [63:0] op_d, fn_d;
    logic        unused_decode;

    logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or;
    logic inst_xor, inst_nor, inst_sll, inst_srl, inst_sra, inst_jr;
    logic inst_addiu, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;
    logic inst_lui, inst_andi, inst_ori, inst_xori, inst_known, special;
    logic [ALU_OP_W-1:0] alu_op;
    logic uses_rs, uses_rt, rs_hazard, rt_hazard, hazard, ds_ready_go;
    logic rf_we, br_taken, rs_eq_rt;
    logic [31:0] br_target;
    ds_to_es_t   ds_out;

    assign ds_pc   = ds_bus_reg[63:32];
    assign ds_inst = ds_bus_reg[31:0];
    assign op      = ds_inst[31:26];
    assign rs      = ds_inst[25:21];
    assign rt      = ds_inst[20:16];
    assign rd      = ds_inst[15:11];
    assign fn      = ds_inst[5:0];
    assign imm     = ds_inst[15:0];

    decoder_6_64 u_op_dec (.in(op), .out(op_d));
    decoder_6_64 u_fn_dec (.in(fn), .out(fn_d));
    assign unused_decode = &{1'b0, op_d, fn_d};

    assign special    = op_d[OP_SPECIAL];
    assign inst_addu  = special & fn_d[FN_ADDU];
    assign inst_subu  = special & fn_d[FN_SUBU];
    assign inst_slt   = special & fn_d[FN_SLT];
    assign inst_sltu  = special & fn_d[FN_SLTU];
    assign inst_and   = special & fn_d[FN_AND];
    assign inst_or    = special & fn_d[FN_OR];
    assign inst_xor   = special & fn_d[FN_XOR];
    assign inst_nor   = special & fn_d[FN_NOR];
    assign inst_sll   = special & fn_d[FN_SLL];
    assign inst_srl   = special & fn_d[FN_SRL];
    assign inst_sra   = special & fn_d[FN_SRA];
    assign inst_jr    = special & fn_d[FN_JR];
    assign inst_addiu = op_d[OP_ADDIU];
    assign inst_lw    = op_d[OP_LW];
    assign inst_sw    = op_d[OP_SW];
    assign inst_beq   = op_d[OP_BEQ];
    assign inst_bne   = op_d[OP_BNE];
    assign inst_jal   = op_d[OP_JAL];
    assign inst_lui   = op_d[OP_LUI];
    assign inst_andi  = op_d[OP_ANDI];
    assign inst_ori   = op_d[OP_ORI];
    assign inst_xori  = op_d[OP_XORI];

    assign inst_known = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or
                      | inst_xor | inst_nor | inst_sll | inst_srl | inst_sra | inst_jr
                      | inst_addiu | inst_lw | inst_sw | inst_beq | inst_bne | inst_jal
                      | inst_lui | inst_andi | inst_ori | inst_xori;

    assign alu_op[ALU_ADD]  = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
    assign alu_op[ALU_SUB]  = inst_subu;
    assign alu_op[ALU_SLT]  = inst_slt;
    assign alu_op[ALU_SLTU] = inst_sltu;
    assign alu_op[ALU_AND]  = inst_and | inst_andi;
    assign alu_op[ALU_NOR]  = inst_nor;
    assign alu_op[ALU_OR]   = inst_or | inst_ori;
    assign alu_op[ALU_XOR]  = inst_xor | inst_xori;
    assign alu_op[ALU_SLL]  = inst_sll;
    assign alu_op[ALU_SRL]  = inst_srl;
    assign alu_op[ALU_SRA]  = inst_sra;
    assign alu_op[ALU_LUI]  = inst_lui;

    assign dest  = inst_jal ? 5'd31
                 : (inst_addiu | inst_lw | inst_lui | inst_andi | inst_ori | inst_xori) ? rt
                 : rd;
    assign rf_we = inst_known & ~(inst_sw | inst_beq | inst_bne | inst_jr);

    assign uses_rs = inst_known & ~(inst_jal | inst_lui | inst_sll | inst_srl | inst_sra);
    assign uses_rt = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or
                   | inst_xor | inst_nor | inst_sll | inst_srl | inst_sra
                   | inst_beq | inst_bne | inst_sw;

    assign rs_addr = rs;
    assign rt_addr = rt;

    byp_mux #(.NUM_BYP(NUM_BYP), .BYP_EN(BYP_EN)) u_rs_mux (
        .src(rs), .used(uses_rs), .rf_data(rs_data),
        .byp_valid(byp_valid), .byp_we(byp_we), .byp_waddr(byp_waddr),
        .byp_wdata(byp_wdata), .byp_data_ok(byp_data_ok),
        .value(rs_val), .hazard(rs_hazard)
    );

    byp_mux #(.NUM_BYP(NUM_BYP), .BYP_EN(BYP_EN)) u_rt_mux (
        .src(rt), .used(uses_rt), .rf_data(rt_data),
        .byp_valid(byp_valid), .byp_we(byp_we), .byp_waddr(byp_waddr),
        .byp_wdata(byp_wdata), .byp_data_ok(byp_data_ok),
        .value(rt_val), .hazard(rt_hazard)
    );

    assign hazard         = rs_hazard | rt_hazard;
    assign ds_ready_go    = ~hazard;
    assign ds_allowin     = ~ds_valid_reg | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_reg & ds_ready_go & ~flush;

    // Branches resolve only in the cycle the instruction moves into execute.
    assign pc4      = ds_pc + 32'd4;
    assign rs_eq_rt = (rs_val == rt_val);
    assign br_taken = ds_to_es_valid & es_allowin
                    & ((inst_beq & rs_eq_rt) | (inst_bne & ~rs_eq_rt) | inst_jal | inst_jr);

    always_comb begin
        br_target = 32'd0;
        if (br_taken) begin
            if (inst_jr)
                br_target = rs_val;
            else if (inst_jal)
                br_target = {pc4[31:28], ds_inst[25:0], 2'b00};
            else
                br_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
        end
    end

    assign br_bus = {br_taken, br_target};

    always_comb begin
        ds_out              = '0;
        ds_out.alu_op       = alu_op;
        ds_out.src1_is_sa   = inst_sll | inst_srl | inst_sra;
        ds_out.src1_is_pc   = inst_jal;
        ds_out.src2_is_imm  = inst_addiu | inst_lw | inst_sw | inst_lui;
        ds_out.src2_is_zimm = inst_andi | inst_ori | inst_xori;
        ds_out.src2_is_8    = inst_jal;
        ds_out.load_op      = inst_lw;
        ds_out.mem_we       = inst_sw;
        ds_out.rf_we        = rf_we;
        ds_out.rf_waddr     = inst_known ? dest : 5'd0;
        ds_out.imm          = imm;
        ds_out.rs_val       = rs_val;
        ds_out.rt_val       = rt_val;
        ds_out.pc           = ds_pc;
    end

    assign ds_to_es_bus = ds_out;
    assign stall_cycles = stall_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid_reg  <= 1'b0;
            ds_bus_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (flush)
                ds_valid_reg <= 1'b0;
            else if (ds_allowin)
                ds_valid_reg <= fs_to_ds_valid;
            if (ds_allowin && fs_to_ds_valid && !flush)
                ds_bus_reg <= fs_to_ds_bus;
            if (ds_valid_reg && hazard && !flush && !(&stall_cnt_reg))
                stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_bypass.sv
// Directed bench for id_stage_bypass: one forwarding instance and one
// interlock-only instance sharing the same stimulus.
module tb_id_stage_bypass;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_allowin;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         flush;
    logic [31:0]  rs_data, rt_data;
    logic [2:0]   byp_valid, byp_we, byp_data_ok;
    logic [14:0]  byp_waddr;
    logic [95:0]  byp_wdata;

    logic         ds_allowin, ds_to_es_valid;
    logic [32:0]  br_bus;
    logic [136:0] ds_to_es_bus;
    logic [4:0]   rs_addr, rt_addr;
    logic [31:0]  stall_cycles;

    logic         ds_allowin_n, ds_to_es_valid_n;
    logic [32:0]  br_bus_n;
    logic [136:0] ds_to_es_bus_n;
    logic [4:0]   rs_addr_n, rt_addr_n;
    logic [31:0]  stall_cycles_n;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    id_stage_bypass #(.NUM_BYP(3), .BYP_EN(1), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .flush(flush),
        .br_bus(br_bus), .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .byp_valid(byp_valid), .byp_we(byp_we), .byp_waddr(byp_waddr),
        .byp_wdata(byp_wdata), .byp_data_ok(byp_data_ok), .stall_cycles(stall_cycles)
    );

    id_stage_bypass #(.NUM_BYP(3), .BYP_EN(0), .STALL_CNT_W(32)) dut_nobyp (
        .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(ds_allowin_n),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .flush(flush),
        .br_bus(br_bus_n), .ds_to_es_valid(ds_to_es_valid_n), .ds_to_es_bus(ds_to_es_bus_n),
        .rs_addr(rs_addr_n), .rt_addr(rt_addr_n), .rs_data(rs_data), .rt_data(rt_data),
        .byp_valid(byp_valid), .byp_we(byp_we), .byp_waddr(byp_waddr),
        .byp_wdata(byp_wdata), .byp_data_ok(byp_data_ok), .stall_cycles(stall_cycles_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_byp();
        byp_valid = '0; byp_we = '0; byp_data_ok = '0; byp_waddr = '0; byp_wdata = '0;
    endtask

    task automatic set_byp(input int idx, input logic [4:0] wa, input logic [31:0] wd,
                           input logic ok);
        byp_valid[idx]         = 1'b1;
        byp_we[idx]            = 1'b1;
        byp_data_ok[idx]       = ok;
        byp_waddr[5*idx +: 5]  = wa;
        byp_wdata[32*idx +: 32] = wd;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, inst};
        tick();
        fs_to_ds_valid = 1'b0;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        reset = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
        flush = 1'b0; rs_data = '0; rt_data = '0;
        clr_byp();
        #1;
        chk("reset_allowin", 64'(ds_allowin), 64'd1);
        chk("reset_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        chk("reset_br_bus", 64'(br_bus), 64'd0);
        chk("reset_stall", 64'(stall_cycles), 64'd0);
        chk("reset_pc", 64'(ds_to_es_bus[31:0]), 64'd0);
        tick(); tick();
        reset = 1'b0;

        // addu $4,$3,$3 with EX forwarding $3=5
        fetch(32'h0, r_ins(5'd3, 5'd3, 5'd4, 6'h21));
        set_byp(0, 5'd3, 32'h5, 1'b1);
        rs_data = 32'hDEAD; rt_data = 32'hDEAD;
        #1;
        chk("fwd_ex_valid", 64'(ds_to_es_valid), 64'd1);
        chk("fwd_ex_rs", 64'(ds_to_es_bus[95:64]), 64'h5);
        chk("fwd_ex_rt", 64'(ds_to_es_bus[63:32]), 64'h5);
        chk("fwd_ex_aluop", 64'(ds_to_es_bus[136:125]), 64'h001);

        // addu $6,$5,$0 behind a load in EX
        fetch(32'h4, r_ins(5'd5, 5'd0, 5'd6, 6'h21));
        clr_byp();
        set_byp(0, 5'd5, 32'h1111, 1'b0);
        rs_data = 32'hDEAD; rt_data = 32'h0;
        #1;
        chk("ld_use_valid", 64'(ds_to_es_valid), 64'd0);
        chk("ld_use_allowin", 64'(ds_allowin), 64'd0);
        chk("ld_use_stall0", 64'(stall_cycles), 64'd0);
        tick();
        clr_byp();
        set_byp(1, 5'd5, 32'hABCD, 1'b1);
        #1;
        chk("ld_use_stall1", 64'(stall_cycles), 64'd1);
        chk("ld_mem_valid", 64'(ds_to_es_valid), 64'd1);
        chk("ld_mem_rs", 64'(ds_to_es_bus[95:64]), 64'hABCD);
        chk("ld_mem_rt", 64'(ds_to_es_bus[63:32]), 64'h0);

        // beq $1,$2 at 0x100
        fetch(32'h100, i_ins(6'h04, 5'd1, 5'd2, 16'h0003));
        clr_byp();
        rs_data = 32'h77; rt_data = 32'h77;
        #1;
        chk("beq_fwd_target", 64'(br_bus), 64'h1_0000_0110);
        es_allowin = 1'b0;
        #1;
        chk("beq_blocked", 64'(br_bus), 64'd0);
        es_allowin = 1'b1;
        fetch(32'h100, i_ins(6'h04, 5'd1, 5'd2, 16'hFFFF));
        #1;
        chk("beq_back_target", 64'(br_bus), 64'h1_0000_0100);
        rt_data = 32'h78;
        #1;
        chk("beq_not_taken", 64'(br_bus), 64'd0);

        // jr $31 with WB then MEM forwarding
        fetch(32'h200, r_ins(5'd31, 5'd0, 5'd0, 6'h08));
        rs_data = 32'h0; rt_data = 32'h0;
        set_byp(2, 5'd31, 32'h400, 1'b1);
        #1;
        chk("jr_wb_target", 64'(br_bus), 64'h1_0000_0400);
        set_byp(1, 5'd31, 32'h500, 1'b1);
        #1;
        chk("jr_priority", 64'(br_bus), 64'h1_0000_0500);

        // producer writing $0 never matches
        fetch(32'h300, r_ins(5'd0, 5'd0, 5'd9, 6'h21));
        clr_byp();
        set_byp(0, 5'd0, 32'h1234, 1'b0);
        #1;
        chk("zero_no_stall", 64'(ds_to_es_valid), 64'd1);
        chk("zero_rs", 64'(ds_to_es_bus[95:64]), 64'h0);

        // ori $7,$8,0x8000
        fetch(32'h304, i_ins(6'h0d, 5'd8, 5'd7, 16'h8000));
        clr_byp();
        #1;
        chk("ori_zimm", 64'(ds_to_es_bus[121]), 64'd1);
        chk("ori_waddr", 64'(ds_to_es_bus[116:112]), 64'd7);
        chk("ori_rf_we", 64'(ds_to_es_bus[117]), 64'd1);
        chk("ori_aluop", 64'(ds_to_es_bus[136:125]), 64'h040);
        chk("ori_imm", 64'(ds_to_es_bus[111:96]), 64'h8000);

        // reset asserted in the middle of a stall
        fetch(32'h308, r_ins(5'd5, 5'd0, 5'd6, 6'h21));
        set_byp(0, 5'd5, 32'h0, 1'b0);
        #1;
        chk("pre_rst_stall", 64'(ds_to_es_valid), 64'd0);
        tick();
        chk("pre_rst_count", 64'(stall_cycles), 64'd2);
        reset = 1'b1; rs_data = '0; rt_data = '0;
        #1;
        chk("rst_mid_valid", 64'(ds_to_es_valid), 64'd0);
        chk("rst_mid_allowin", 64'(ds_allowin), 64'd1);
        chk("rst_mid_count", 64'(stall_cycles), 64'd0);
        chk("rst_mid_br", 64'(br_bus), 64'd0);
        chk("rst_mid_pc", 64'(ds_to_es_bus[31:0]), 64'd0);
        tick();
        reset = 1'b0;
        clr_byp();

        // interlock-only instance: MEM match stalls until it leaves
        fetch(32'h400, r_ins(5'd5, 5'd0, 5'd6, 6'h21));
        rs_data = 32'h55;
        set_byp(1, 5'd5, 32'hABCD, 1'b1);
        #1;
        chk("nobyp_stall", 64'(ds_to_es_valid_n), 64'd0);
        chk("byp_same_vec_rs", 64'(ds_to_es_bus[95:64]), 64'hABCD);
        tick();
        chk("nobyp_count1", 64'(stall_cycles_n), 64'd1);
        clr_byp();
        #1;
        chk("nobyp_release", 64'(ds_to_es_valid_n), 64'd1);
        chk("nobyp_rf_rs", 64'(ds_to_es_bus_n[95:64]), 64'h55);
        set_byp(1, 5'd5, 32'hABCD, 1'b1);
        tick();
        chk("nobyp_count2", 64'(stall_cycles_n), 64'd2);
        flush = 1'b1;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus = {32'h500, r_ins(5'd1, 5'd2, 5'd3, 6'h21)};
        #1;
        chk("flush_blocks_valid", 64'(ds_to_es_valid_n), 64'd0);
        tick();
        flush = 1'b0; fs_to_ds_valid = 1'b0;
        #1;
        chk("flush_count_frozen", 64'(stall_cycles_n), 64'd2);
        chk("flush_cleared", 64'(ds_to_es_valid_n), 64'd0);
        chk("flush_allowin", 64'(ds_allowin_n), 64'd1);
        chk("flush_no_capture", 64'(ds_to_es_bus_n[31:0]), 64'h400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_stage_bypass.md
# id_stage_bypass

Parametrised decode stage for the 5-stage MIPS pipeline. It sits between the fetch and execute stages and uses the same valid/allowin handshake. It adds three things:
- operand bypassing from up to `NUM_BYP` downstream producer stages;
- a load-use / not-ready interlock;
- a flush input and a saturating stall-cycle counter.

Branches and jumps resolve here with forwarded operands.

## Interface
Parameters:
- `NUM_BYP`, 3: number of producer stages. Index 0 is the youngest (EX), then MEM, then WB.
- `BYP_EN`, 1: 1 enables forwarding. 0 gives pure interlock: any register match stalls until that producer leaves the bypass list.
- `STALL_CNT_W`, 32: width of the stall counter.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `es_allowin` in 1: execute stage can accept an instruction.
- `ds_allowin` out 1: this stage can accept an instruction.
- `fs_to_ds_valid` in 1: fetch stage presents an instruction.
- `fs_to_ds_bus` in 64: {pc[31:0], inst[31:0]}.
- `flush` in 1: discard the held instruction.
- `br_bus` out 33: {br_taken, br_target[31:0]}.
- `ds_to_es_valid` out 1: instruction valid to execute.
- `ds_to_es_bus` out 137: {alu_op[11:0], src1_is_sa, src1_is_pc, src2_is_imm, src2_is_zimm, src2_is_8, load_op, mem_we, rf_we, rf_waddr[4:0], imm[15:0], rs_val[31:0], rt_val[31:0], pc[31:0]}, MSB first.
- `rs_addr`, `rt_addr` out 5: register file read addresses.
- `rs_data`, `rt_data` in 32: combinational register file read data.
- `byp_valid` in NUM_BYP: producer holds a valid instruction.
- `byp_we` in NUM_BYP: producer writes the register file.
- `byp_waddr` in 5*NUM_BYP: producer destination register.
- `byp_wdata` in 32*NUM_BYP: producer result.
- `byp_data_ok` in NUM_BYP: the producer's result is available (0 for a load in EX).
- `stall_cycles` out STALL_CNT_W: saturating count of hazard stall cycles.

## Operation
- Pipeline registers:
  - `ds_valid` loads `fs_to_ds_valid` when `ds_allowin` is high.
  - The 64-bit bus register loads when `ds_allowin && fs_to_ds_valid`.
  - `flush` clears `ds_valid` next edge and overrides any load.
- Instruction decode:
  - Set: addu, addiu, subu, lw, sw, beq, bne, jal, jr, slt, sltu, sll, srl, sra, lui, and, or, xor, nor, andi, ori, xori.
  - andi, ori, xori use the and/or/xor alu_op bits with `src2_is_zimm`=1.
  - Unknown opcodes decode to all-zero controls; `rf_we`=0.
- Destination register:
  - 31 for jal.
  - rt for addiu, lw, lui, andi, ori, xori.
  - rd otherwise.
  - `rf_we`=0 for sw, beq, bne, jr.
- Operand use:
  - `uses_rs` = everything except jal, lui, sll, srl, sra.
  - `uses_rt` = R-type ALU ops, shifts, beq, bne, sw.
- Match rule: producer i matches a source register when `byp_valid[i] && byp_we[i] && byp_waddr[i]==src && src!=0`.
- Operand value:
  - Taken from the lowest-index matching producer; register file data if none match.
  - With `BYP_EN`=0, operand values always come from the register file.
- Stall:
  - `hazard` = a used source has a selected match with `byp_data_ok`=0.
  - With `BYP_EN`=0, any match on a used source is a hazard.
  - `ds_ready_go` = ~hazard.
  - `ds_allowin` = ~ds_valid | (ds_ready_go & es_allowin).
  - `ds_to_es_valid` = ds_valid & ds_ready_go & ~flush.
- Branch resolution:
  - Conditions are evaluated on the forwarded values.
  - `br_taken` = ds_to_es_valid & es_allowin & (beq&eq | bne&~eq | jal | jr).
  - Targets use pc4 = pc+4 (delay slot):
    - beq/bne: pc4 + {sext(imm),2'b00};
    - jal: {pc4[31:28], jidx, 2'b00};
    - jr: forwarded rs.
  - `br_target` is 0 when `br_taken` is low.
- Stall counter: increments each cycle that `ds_valid & hazard & ~flush`; holds at all-ones.

## Timing
- Reset values:
  - `ds_valid`=0, bus register=0, `stall_cycles`=0;
  - hence `ds_allowin`=1, `ds_to_es_valid`=0, `br_bus`=0.
- Latency: one cycle, fetch to decode register; decode outputs are combinational from the register.
- Hazard stall: the instruction holds until the producer's `byp_data_ok` rises or the match leaves the list. Forwarded data is used in the same cycle `byp_data_ok` rises.
- Simultaneous events:
  - flush and stall together: flush wins; counter not incremented.
  - flush and new fetch together: fetch not captured.
- `br_taken` pulses once per instruction, in its transfer cycle only.
- Reset asserted mid-operation clears state immediately (asynchronous).

## Structure
- Shared package `cpu_pkg`: bus widths (64/33/137), opcode and func constants, alu_op bit indices.
- Sub-module `byp_mux`, instantiated twice (rs, rt):
  - inputs: source register, used flag, register file data, bypass vectors;
  - outputs: value, hazard.
- Reuse `decoder_6_64` for opcode and func decode.

## Test plan
- Back-to-back `addu $3,$1,$2` then `addu $4,$3,$3`: EX forwards 0x5 with data_ok=1 → no stall, rs_val=rt_val=0x5.
- `lw $5` in EX with data_ok=0, then `addu $6,$5,$0` in decode → one stall cycle, stall_cycles=1; MEM then forwards 0xABCD → rs_val=0xABCD.
- beq at pc=0x100, imm=0x0003, equal operands → br_bus = {1, 0x110}. Repeat with imm=0xFFFF → target 0x100.
- jr $31 with WB forwarding 0x400 while the register file returns 0 → br_target=0x400.
- `BYP_EN`=0: a match in MEM stalls until it clears; flush during the stall → ds_valid=0 next cycle, counter frozen.
- Match on $0 is ignored; ori with imm=0x8000 → src2_is_zimm=1, rf_waddr=rt. Reset mid-stall → all outputs return to reset values.
